// File: rtl/count_seq_checker_pkg.sv
// Shared types and constants for the count sequence checker.
package count_seq_pkg;

    localparam int COUNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam state_t               STATE_RST = ST_IDLE;
    localparam logic [COUNT_W-1:0]   LAST_RST  = '0;
    localparam logic [3:0]           RUN_RST   = '0;
    localparam logic [3:0]           BAD_RST   = '0;

    function automatic logic [COUNT_W-1:0] next_count(input logic [COUNT_W-1:0] v);
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/count_seq_checker_if.sv
// Sample/status bundle between the upstream counter side and the checker.
interface count_seq_checker_if import count_seq_pkg::*; #(
    parameter int WRAP_W = 8
) ();
    logic               clear;
    logic               count_valid;
    logic [COUNT_W-1:0] count_in;
    logic [1:0]         state;
    logic               locked;
    logic               fault;
    logic               mismatch;
    logic               wrap_pulse;
    logic [WRAP_W-1:0]  wrap_cnt;
    logic [7:0]         err_cnt;

    modport master (
        output clear, count_valid, count_in,
        input  state, locked, fault, mismatch, wrap_pulse, wrap_cnt, err_cnt
    );

    modport slave (
        input  clear, count_valid, count_in,
        output state, locked, fault, mismatch, wrap_pulse, wrap_cnt, err_cnt
    );
endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/count_seq_checker.sv
// Checks that sampled values of a 3-bit up counter advance by one each sample.
// Optional statistics (wrap_cnt, err_cnt) are built only with COUNT_SEQ_CHECKER_STATS_EN.
//
// state      | meaning
// IDLE       | waiting for a first sample to seed "last"
// ACQUIRE    | counting consecutive good increments toward lock
// TRACK      | locked; mismatches counted, too many in a row -> FAULT
// FAULT      | sticky error; samples ignored until clear or reset
module count_seq_checker import count_seq_pkg::*; #(
    parameter int LOCK_CNT  = 4,
    parameter int ERR_LIMIT = 2,
    parameter int WRAP_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    count_seq_checker_if.slave   bus
);

    localparam logic [3:0] RUN_LAST = 4'(LOCK_CNT - 1);
    localparam logic [3:0] BAD_LAST = 4'(ERR_LIMIT - 1);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] last_q, last_d;
    logic [3:0]         run, bad_run;
    logic               run_inc, run_clr, bad_inc, bad_clr;
    logic               good;
    logic               mismatch_d, wrap_d;
    logic               mismatch_q, wrap_q, locked_q, fault_q;

    assign good = (bus.count_in == next_count(last_q));

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        run_inc    = 1'b0;
        run_clr    = bus.clear;
        bad_inc    = 1'b0;
        bad_clr    = bus.clear;
        mismatch_d = 1'b0;
        wrap_d     = 1'b0;
        if (bus.clear) begin
            state_d = STATE_RST;
            last_d  = LAST_RST;
        end else if (bus.count_valid) begin
            case (state_q)
                ST_IDLE: begin
                    last_d  = bus.count_in;
                    run_clr = 1'b1;
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    last_d = bus.count_in;
                    if (good) begin
                        run_inc = 1'b1;
                        wrap_d  = &last_q;
                        if (run == RUN_LAST)
                            state_d = ST_TRACK;
                    end else begin
                        run_clr = 1'b1;
                    end
                end
                ST_TRACK: begin
                    last_d = bus.count_in;
                    if (good) begin
                        bad_clr = 1'b1;
                        wrap_d  = &last_q;
                    end else begin
                        mismatch_d = 1'b1;
                        bad_inc    = 1'b1;
                        if (bad_run == BAD_LAST)
                            state_d = ST_FAULT;
                    end
                end
                ST_FAULT: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= STATE_RST;
            last_q     <= LAST_RST;
            mismatch_q <= 1'b0;
            wrap_q     <= 1'b0;
            locked_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            mismatch_q <= mismatch_d;
            wrap_q     <= wrap_d;
            locked_q   <= (state_d == ST_TRACK);
            fault_q    <= (state_d == ST_FAULT);
        end
    end

    sat_counter #(.WIDTH(4)) u_run (
        .clk(clk), .reset(reset), .inc(run_inc), .clr(run_clr), .q(run)
    );

    sat_counter #(.WIDTH(4)) u_bad_run (
        .clk(clk), .reset(reset), .inc(bad_inc), .clr(bad_clr), .q(bad_run)
    );

`ifdef COUNT_SEQ_CHECKER_STATS_EN
    // Wraps are only tallied once locked; ACQUIRE wraps still pulse.
    logic wrap_inc;
    assign wrap_inc = wrap_d && (state_q == ST_TRACK);

    sat_counter #(.WIDTH(WRAP_W)) u_wrap_cnt (
        .clk(clk), .reset(reset), .inc(wrap_inc), .clr(bus.clear), .q(bus.wrap_cnt)
    );

    sat_counter #(.WIDTH(8)) u_err_cnt (
        .clk(clk), .reset(reset), .inc(mismatch_d), .clr(bus.clear), .q(bus.err_cnt)
    );
`else
    assign bus.wrap_cnt = WRAP_W'(0);
    assign bus.err_cnt  = 8'd0;
`endif

    assign bus.state      = state_q;
    assign bus.locked     = locked_q;
    assign bus.fault      = fault_q;
    assign bus.mismatch   = mismatch_q;
    assign bus.wrap_pulse = wrap_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Self-checking bench for count_seq_checker: directed table, corner sequences, random run.
module tb_count_seq_checker;

    localparam int LOCK  = 4;
    localparam int ERRL  = 2;
    localparam int WW    = 8;
`ifdef COUNT_SEQ_CHECKER_STATS_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    count_seq_checker_if #(.WRAP_W(WW)) bus ();

    count_seq_checker #(.LOCK_CNT(LOCK), .ERR_LIMIT(ERRL), .WRAP_W(WW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        bit       clr;
        bit       v;
        bit [2:0] din;
        int       st;
        bit       mm;
        bit       wp;
        int       wc;
        int       ec;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int m_state, m_last, m_run, m_bad, m_wrap, m_err;
    bit m_mis, m_wp;

    function automatic void model_reset();
        m_state = 0; m_last = 0; m_run = 0; m_bad = 0;
        m_wrap = 0; m_err = 0; m_mis = 0; m_wp = 0;
    endfunction

    function automatic void model_apply(bit c, bit v, int d);
        bit g;
        m_mis = 0;
        m_wp  = 0;
        if (c) begin
            model_reset();
        end else if (v && m_state != 3) begin
            g = (d == (m_last + 1) % 8);
            if (m_state == 0) begin
                m_run = 0;
                m_state = 1;
            end else if (m_state == 1) begin
                if (g) begin
                    m_run++;
                    m_wp = (m_last == 7);
                    if (m_run >= LOCK) m_state = 2;
                end else begin
                    m_run = 0;
                end
            end else begin
                if (g) begin
                    m_bad = 0;
                    if (m_last == 7) begin
                        m_wp = 1;
                        if (S == 1 && m_wrap < 255) m_wrap++;
                    end
                end else begin
                    m_mis = 1;
                    if (S == 1 && m_err < 255) m_err++;
                    m_bad++;
                    if (m_bad >= ERRL) m_state = 3;
                end
            end
            m_last = d;
        end
    endfunction

    task automatic check_outputs(string name, int st, bit mm, bit wp, int wc, int ec);
        vectors++;
        if (bus.state !== 2'(st) || bus.locked !== (st == 2) || bus.fault !== (st == 3) ||
            bus.mismatch !== mm || bus.wrap_pulse !== wp ||
            bus.wrap_cnt !== WW'(wc) || bus.err_cnt !== 8'(ec)) begin
            miscompares++;
            $display("FAIL %s: got st=%0d lk=%0b ft=%0b mm=%0b wp=%0b wc=%0d ec=%0d, want st=%0d lk=%0b ft=%0b mm=%0b wp=%0b wc=%0d ec=%0d",
                     name, bus.state, bus.locked, bus.fault, bus.mismatch, bus.wrap_pulse,
                     bus.wrap_cnt, bus.err_cnt, st, (st == 2), (st == 3), mm, wp, wc, ec);
        end
    endtask

    task automatic step(bit c, bit v, bit [2:0] d, string name);
        bus.clear = c;
        bus.count_valid = v;
        bus.count_in = d;
        @(posedge clk);
        #1;
        model_apply(c, v, int'(d));
        check_outputs(name, m_state, m_mis, m_wp, m_wrap, m_err);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.clear = 1'b0;
        bus.count_valid = 1'b0;
        bus.count_in = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outputs("reset", 0, 0, 0, 0, 0);
        reset = 1'b1;
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{0, 1, 3'd3, 1, 0, 0, 0,     0};
        tbl[1]  = '{0, 1, 3'd4, 1, 0, 0, 0,     0};
        tbl[2]  = '{0, 1, 3'd5, 1, 0, 0, 0,     0};
        tbl[3]  = '{0, 1, 3'd6, 1, 0, 0, 0,     0};
        tbl[4]  = '{0, 1, 3'd7, 2, 0, 0, 0,     0};
        tbl[5]  = '{0, 1, 3'd0, 2, 0, 1, S,     0};
        tbl[6]  = '{0, 1, 3'd1, 2, 0, 0, S,     0};
        tbl[7]  = '{0, 1, 3'd2, 2, 0, 0, S,     0};
        tbl[8]  = '{0, 1, 3'd5, 2, 1, 0, S,     S};
        tbl[9]  = '{0, 1, 3'd7, 3, 1, 0, S,     2 * S};
        tbl[10] = '{0, 1, 3'd0, 3, 0, 0, S,     2 * S};
        tbl[11] = '{0, 0, 3'd1, 3, 0, 0, S,     2 * S};
        tbl[12] = '{1, 1, 3'd4, 0, 0, 0, 0,     0};
        tbl[13] = '{0, 1, 3'd5, 1, 0, 0, 0,     0};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].clr, tbl[i].v, tbl[i].din, $sformatf("model_row%0d", i));
            check_outputs($sformatf("table_row%0d", i), tbl[i].st, tbl[i].mm, tbl[i].wp,
                          tbl[i].wc, tbl[i].ec);
        end
        // sample 4 was discarded by clear: 6 must follow 5 as a good increment
        step(0, 1, 3'd6, "after_clear_good");

        // ACQUIRE with run=3 then a bad sample; relock; then saturate wrap_cnt
        do_reset();
        step(0, 1, 3'd0, "acq_seed");
        step(0, 1, 3'd1, "acq_run1");
        step(0, 1, 3'd2, "acq_run2");
        step(0, 1, 3'd3, "acq_run3");
        step(0, 1, 3'd6, "acq_bad");
        check_outputs("acq_bad_nomis", 1, 0, 0, 0, 0);
        step(0, 1, 3'd7, "acq_re1");
        step(0, 1, 3'd0, "acq_re2_wrap");
        check_outputs("acq_wrap_uncounted", 1, 0, 1, 0, 0);
        step(0, 1, 3'd1, "acq_re3");
        step(0, 1, 3'd2, "acq_re4_lock");
        check_outputs("relock", 2, 0, 0, 0, 0);
        for (int i = 0; i < 2400; i++)
            step(0, 1, 3'((m_last + 1) % 8), "wrap_loop");
        check_outputs("wrap_sat", 2, 0, 0, 255 * S, 0);

        // asynchronous reset between edges while tracking
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 1, 3'd6, "post_reset_idle");
        check_outputs("post_reset_acq", 1, 0, 0, 0, 0);

        // randomized run biased toward correct increments
        for (int i = 0; i < 3000; i++) begin
            bit c, v;
            bit [2:0] d;
            c = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 8) d = 3'((m_last + 1) % 8);
            else d = 3'($urandom_range(0, 7));
            step(c, v, d, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive correct increments required to enter TRACK (legal range 1..15).
REQ-002 Parameter ERR_LIMIT, default 2: consecutive mismatches in TRACK that force FAULT (legal range 1..15).
REQ-003 Parameter WRAP_W, default 8: width of the wrap counter output.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low forces every register to its reset value immediately.
REQ-006 clear  input  1  synchronous soft clear; returns the block to IDLE.
REQ-007 count_valid  input  1  count_in carries a new sample this cycle.
REQ-008 count_in  input  3  sampled value of the upstream 3-bit up counter.
REQ-009 state  output  2  current FSM state: IDLE=0, ACQUIRE=1, TRACK=2, FAULT=3.
REQ-010 locked  output  1  high while state is TRACK.
REQ-011 fault  output  1  high while state is FAULT.
REQ-012 mismatch  output  1  single-cycle pulse for a mismatched sample.
REQ-013 wrap_pulse  output  1  single-cycle pulse for a 7->0 transition.
REQ-014 wrap_cnt  output  WRAP_W  saturating count of wraps seen in TRACK.
REQ-015 err_cnt  output  8  saturating count of mismatches in TRACK.

Function
REQ-016 All outputs are registered; a sample's effect is visible on the outputs exactly 1 cycle after the rising edge on which count_valid=1.
REQ-017 Expected value = (last sample + 1) mod 8; a sample is good when count_in equals the expected value, otherwise bad.
REQ-018 IDLE: a valid sample is stored as last, run counter is zeroed, and the FSM moves to ACQUIRE; no good/bad judgement is made.
REQ-019 ACQUIRE: good sample -> run+1, and when run reaches LOCK_CNT the FSM moves to TRACK; bad sample -> run=0, stay in ACQUIRE, mismatch not pulsed.
REQ-020 TRACK: good sample -> bad-run counter cleared; bad sample -> mismatch pulse, err_cnt+1, bad-run+1, and the FSM moves to FAULT when bad-run reaches ERR_LIMIT.
REQ-021 In IDLE, ACQUIRE and TRACK, last is updated to count_in on every valid sample, including bad ones (resynchronisation).
REQ-022 FAULT is sticky: valid samples are ignored and no pulses are produced until clear or reset.
REQ-023 wrap_pulse fires for a good sample with last=7 and count_in=0 in ACQUIRE or TRACK; wrap_cnt increments only in TRACK.
REQ-024 wrap_cnt and err_cnt saturate at their all-ones value and never roll over.
REQ-025 clear=1 has priority over count_valid: a simultaneous sample is discarded, the FSM goes to IDLE, and all counters and pulses are zeroed on the next cycle.
REQ-026 Cycles with count_valid=0 change no state except pulse deassertion.

Reset
REQ-027 Reset low: state=IDLE, last=0, run=0, bad-run=0, locked=0, fault=0, mismatch=0, wrap_pulse=0, wrap_cnt=0, err_cnt=0.
REQ-028 Reset asserted mid-operation, including in FAULT, aborts everything; the first valid sample after release is treated as an IDLE sample.

Configuration
REQ-029 Macro COUNT_SEQ_CHECKER_STATS_EN defined: wrap_cnt and err_cnt are implemented as specified.
REQ-030 Macro not defined: no statistics registers exist, and wrap_cnt and err_cnt are tied to 0; the FSM, locked, fault, mismatch and wrap_pulse are unchanged.

Structure
REQ-031 Package count_seq_pkg holds COUNT_W=3, the 2-bit state typedef and encodings, and the per-state reset constants.
REQ-032 Sub-module sat_counter (parameter width, inc, clr, async active-low reset) implements run, bad-run, wrap_cnt and err_cnt.

Verification
REQ-033 Reset, then samples 3,4,5,6,7 -> ACQUIRE after 3; locked=1 one cycle after the sample 7 (4 good increments).
REQ-034 In TRACK, samples 7,0,1 -> wrap_pulse one cycle after 0, wrap_cnt=1, mismatch stays 0.
REQ-035 In TRACK at last=2, samples 5 then 7 -> two mismatch pulses, err_cnt=2, fault=1 after the second (ERR_LIMIT=2); further samples are ignored.
REQ-036 In FAULT, clear=1 with count_valid=1 and count_in=4 -> next cycle state=IDLE and counters=0; the sample 4 is not stored.
REQ-037 In ACQUIRE with run=3, bad sample -> run=0 and no mismatch pulse; 300 wraps in TRACK -> wrap_cnt holds 255.
REQ-038 Reset pulsed low mid-TRACK asynchronously between edges -> all outputs 0 immediately; build without COUNT_SEQ_CHECKER_STATS_EN and rerun REQ-034 -> wrap_cnt=0 while wrap_pulse still fires.
